// File: rtl/ecc_decoder.sv
// Registered extended-Hamming SECDED decoder: one codeword per cycle in,
// corrected data plus error status and syndrome one clock later.
module ecc_decoder #(
    parameter int data_bit_width      = 64,
    parameter int redundant_bit_width = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          dec_valid_in,
    input  logic [data_bit_width+redundant_bit_width-1:0] dec_data_in,
    output logic                                          dec_valid_out,
    output logic [data_bit_width-1:0]                     dec_data_out,
    output logic                                          dec_sec_err,
    output logic                                          dec_ded_err,
    output logic [redundant_bit_width-1:0]                dec_syndrome
);

    localparam int D = data_bit_width;
    localparam int R = redundant_bit_width;
    localparam int N = D + R;

    // Positions covered by Hamming check bit m+1: every k >= 1 with bit m of k set.
    function automatic logic [N-1:0] col_mask(input int unsigned m);
        logic [N-1:0] mask;
        mask = '0;
        for (int unsigned k = 1; k < N; k++) begin
            mask[k] = ((k >> m) & 1) != 0;
        end
        return mask;
    endfunction

    logic [R-2:0] s;
    logic         p;
    logic         s_nonzero;
    logic         in_range;
    logic         correct;
    logic         sec;
    logic         ded;
    logic [D-1:0] data_ext;

    for (genvar m = 0; m < R - 1; m++) begin : g_syn
        assign s[m] = ^(dec_data_in & col_mask(m));
    end

    assign p = ^dec_data_in;

    always_comb begin
        s_nonzero = (s != '0);
        in_range  = (int'(s) < N);
        correct   = p && s_nonzero && in_range;
        sec       = p && (!s_nonzero || in_range);
        ded       = s_nonzero && (!p || !in_range);
    end

    // Data bits sit at every non-power-of-two position; flip the one the syndrome names.
    for (genvar j = 1; j < N; j++) begin : g_ext
        if ((j & (j - 1)) != 0) begin : g_bit
            assign data_ext[j - $clog2(j) - 1] = dec_data_in[j] ^ (correct && (int'(s) == j));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_valid_out <= 1'b0;
            dec_data_out  <= '0;
            dec_sec_err   <= 1'b0;
            dec_ded_err   <= 1'b0;
            dec_syndrome  <= '0;
        end else begin
            dec_valid_out <= dec_valid_in;
            if (dec_valid_in) begin
                dec_data_out <= data_ext;
                dec_sec_err  <= sec;
                dec_ded_err  <= ded;
                dec_syndrome <= {s, p};
            end
        end
    end

endmodule

// File: tb/tb_ecc_decoder.sv
// Randomized and directed bench for ecc_decoder against a position-XOR
// reference model of extended-Hamming SECDED.
module tb_ecc_decoder;

    localparam int D = 64;
    localparam int R = 8;
    localparam int N = D + R;

    logic         clk;
    logic         rst;
    logic         dec_valid_in;
    logic [N-1:0] dec_data_in;
    logic         dec_valid_out;
    logic [D-1:0] dec_data_out;
    logic         dec_sec_err;
    logic         dec_ded_err;
    logic [R-1:0] dec_syndrome;

    int checks = 0;
    int errors = 0;

    // Expected register contents after the next rising edge
    logic         exp_valid;
    logic [D-1:0] exp_data;
    logic         exp_sec;
    logic         exp_ded;
    logic [R-1:0] exp_syn;

    ecc_decoder #(
        .data_bit_width     (D),
        .redundant_bit_width(R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid_in (dec_valid_in),
        .dec_data_in  (dec_data_in),
        .dec_valid_out(dec_valid_out),
        .dec_data_out (dec_data_out),
        .dec_sec_err  (dec_sec_err),
        .dec_ded_err  (dec_ded_err),
        .dec_syndrome (dec_syndrome)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_pow2(input int unsigned j);
        return (j & (j - 1)) == 0;
    endfunction

    // A valid codeword has the XOR of all set-bit positions equal to zero and even parity.
    function automatic logic [N-1:0] encode(input logic [D-1:0] d);
        logic [N-1:0] cw;
        int unsigned  di;
        int unsigned  pos_xor;
        cw = '0;
        di = 0;
        pos_xor = 0;
        for (int unsigned j = 1; j < N; j++) begin
            if (!is_pow2(j)) begin
                cw[j] = d[di];
                if (d[di]) pos_xor ^= j;
                di++;
            end
        end
        for (int unsigned m = 0; m < R - 1; m++) begin
            cw[1 << m] = ((pos_xor >> m) & 1) != 0;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [D-1:0] extract(input logic [N-1:0] cw);
        logic [D-1:0] d;
        int unsigned  di;
        d = '0;
        di = 0;
        for (int unsigned j = 1; j < N; j++) begin
            if (!is_pow2(j)) begin
                d[di] = cw[j];
                di++;
            end
        end
        return d;
    endfunction

    task automatic ref_decode(input logic [N-1:0] cw, output logic [D-1:0] d,
                              output logic sec, output logic ded, output logic [R-1:0] syn);
        int unsigned  pos_xor;
        logic         par;
        logic [N-1:0] fixed;
        pos_xor = 0;
        for (int unsigned k = 1; k < N; k++) begin
            if (cw[k]) pos_xor ^= k;
        end
        par   = ^cw;
        fixed = cw;
        sec   = 1'b0;
        ded   = 1'b0;
        if (pos_xor == 0) begin
            sec = par;
        end else if (par && pos_xor < N) begin
            fixed[pos_xor] = ~fixed[pos_xor];
            sec = 1'b1;
        end else begin
            ded = 1'b1;
        end
        d   = extract(fixed);
        syn = {pos_xor[R-2:0], par};
    endtask

    task automatic check_outputs();
        check("valid_out", 128'(dec_valid_out), 128'(exp_valid));
        check("data_out",  128'(dec_data_out),  128'(exp_data));
        check("sec_err",   128'(dec_sec_err),   128'(exp_sec));
        check("ded_err",   128'(dec_ded_err),   128'(exp_ded));
        check("syndrome",  128'(dec_syndrome),  128'(exp_syn));
    endtask

    task automatic clear_model();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_sec   = 1'b0;
        exp_ded   = 1'b0;
        exp_syn   = '0;
    endtask

    // At each falling edge: verify the previous cycle's result, then present the next input.
    task automatic step(input logic v, input logic [N-1:0] cw);
        @(negedge clk);
        check_outputs();
        dec_valid_in = v;
        dec_data_in  = cw;
        exp_valid    = v;
        if (v) ref_decode(cw, exp_data, exp_sec, exp_ded, exp_syn);
    endtask

    function automatic logic [D-1:0] rand_data();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [D-1:0] base;
        logic [N-1:0] cw;
        logic [N-1:0] cw_ones;

        rst          = 1'b1;
        dec_valid_in = 1'b0;
        dec_data_in  = '0;
        clear_model();

        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Clean word
        base = 64'h0123456789ABCDEF;
        step(1'b1, encode(base));
        step(1'b0, '0);
        check("clean_data", 128'(dec_data_out), 128'(base));
        check("clean_syn",  128'(dec_syndrome), 128'(0));

        // Every single-bit flip is corrected
        for (int unsigned i = 0; i < N; i++) begin
            cw = encode(base);
            cw[i] = ~cw[i];
            step(1'b1, cw);
            step(1'b0, '0);
            check("single_data", 128'(dec_data_out), 128'(base));
            check("single_sec",  128'(dec_sec_err),  128'(1));
            check("single_ded",  128'(dec_ded_err),  128'(0));
            check("single_syn",  128'(dec_syndrome), 128'((i << 1) | 1));
        end

        // Double error
        cw = encode({D{1'b1}});
        cw[3] = ~cw[3];
        cw[5] = ~cw[5];
        step(1'b1, cw);
        step(1'b0, '0);
        check("double_ded", 128'(dec_ded_err),  128'(1));
        check("double_sec", 128'(dec_sec_err),  128'(0));
        check("double_syn", 128'(dec_syndrome), 128'(8'h0C));

        // Out-of-range syndrome with odd parity
        cw_ones = '0;
        for (int unsigned m = 0; m < R - 1; m++) cw_ones[1 << m] = 1'b1;
        step(1'b1, cw_ones);
        step(1'b0, '0);
        check("range_ded", 128'(dec_ded_err),  128'(1));
        check("range_sec", 128'(dec_sec_err),  128'(0));
        check("range_syn", 128'(dec_syndrome), 128'(8'hFF));

        // Back-to-back random words with occasional injected errors
        for (int n = 0; n < 1000; n++) begin
            cw = encode(rand_data());
            case ($urandom_range(3))
                1: cw[$urandom_range(N - 1)] ^= 1'b1;
                2: begin
                    int unsigned a;
                    int unsigned b;
                    a = $urandom_range(N - 1);
                    b = (a + 1 + $urandom_range(N - 2)) % N;
                    cw[a] ^= 1'b1;
                    cw[b] ^= 1'b1;
                end
                default: ;
            endcase
            step(1'b1, cw);
        end

        // Outputs hold while valid is low
        for (int n = 0; n < 20; n++) begin
            step(($urandom_range(3) == 0), {rand_data(), 8'($urandom())});
        end
        for (int n = 0; n < 5; n++) step(1'b0, {rand_data(), 8'($urandom())});

        // Asynchronous reset mid-stream discards the word in flight
        step(1'b1, encode(rand_data()));
        step(1'b1, encode(base));
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        dec_valid_in = 1'b0;
        rst = 1'b0;
        step(1'b1, encode(64'hDEADBEEFCAFEF00D));
        step(1'b0, '0);
        check("post_rst_data", 128'(dec_data_out), 128'(64'hDEADBEEFCAFEF00D));
        for (int n = 0; n < 3; n++) step(1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
